// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage pipelined floating-point add/subtract with compare,
// round-to-nearest-even, flush-to-zero inputs and a tag carried through.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     result,
    output logic [1:0]       compare,
    output logic [2:0]       flags,
    output logic [TAG_W-1:0] out_tag
);
    localparam int SW = MAN_W + 4;
    localparam int LW = $clog2(SW + 1);
    localparam int EW = EXP_W + 2;
    localparam int RW = MAN_W + 2;
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sa, sb, swap, inf_clash;
    logic             c1_spec, c1_inv;
    logic [W-1:0]     bx, xw, yw, c1_res;
    logic [W-2:0]     a_mag, b_mag;
    logic [1:0]       c1_cmp;
    logic [EXP_W-1:0] dexp;
    logic [SW-1:0]    xsig, ysig, yal;

    always_comb begin
        bx        = {b[W-1] ^ op, b[W-2:0]};
        a_zero    = a[W-2 -: EXP_W] == '0;
        b_zero    = b[W-2 -: EXP_W] == '0;
        a_inf     = a[W-2 -: EXP_W] == EMAX && a[MAN_W-1:0] == '0;
        b_inf     = b[W-2 -: EXP_W] == EMAX && b[MAN_W-1:0] == '0;
        a_nan     = a[W-2 -: EXP_W] == EMAX && a[MAN_W-1:0] != '0;
        b_nan     = b[W-2 -: EXP_W] == EMAX && b[MAN_W-1:0] != '0;
        inf_clash = a_inf && b_inf && a[W-1] != bx[W-1];
        c1_inv    = (a_nan && !a[MAN_W-1]) || (b_nan && !b[MAN_W-1]) || inf_clash;
        c1_spec   = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
        c1_res    = (a_nan || b_nan || inf_clash) ? QNAN :
                    a_inf ? a :
                    b_inf ? bx :
                    (a_zero && b_zero) ? {a[W-1] & bx[W-1], {(W-1){1'b0}}} :
                    a_zero ? bx : a;
        // compare uses the original b with zeros folded to +0
        a_mag     = a_zero ? '0 : a[W-2:0];
        b_mag     = b_zero ? '0 : b[W-2:0];
        sa        = a[W-1] && a_mag != '0;
        sb        = b[W-1] && b_mag != '0;
        c1_cmp    = (a_nan || b_nan) ? 2'd3 :
                    (a_mag == b_mag && sa == sb) ? 2'd2 :
                    (sa != sb) ? {1'b0, sa} :
                    ((a_mag > b_mag) ^ sa) ? 2'd0 : 2'd1;
        swap      = b[W-2:0] > a[W-2:0];
        xw        = swap ? bx : a;
        yw        = swap ? a : bx;
        dexp      = xw[W-2 -: EXP_W] - yw[W-2 -: EXP_W];
        xsig      = {1'b1, xw[MAN_W-1:0], 3'b000};
        ysig      = {1'b1, yw[MAN_W-1:0], 3'b000};
        yal       = int'(dexp) >= MAN_W + 3 ? SW'(1) :
                    (ysig >> dexp) | SW'(|(ysig & ~({SW{1'b1}} << dexp)));
    end

    logic             v1, spec1, inv1, sub1, sgn1;
    logic [TAG_W-1:0] tag1;
    logic [W-1:0]     res1;
    logic [1:0]       cmp1;
    logic [EXP_W-1:0] exp1;
    logic [SW-1:0]    xsig1, ysig1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            spec1 <= 1'b0;
            inv1  <= 1'b0;
            sub1  <= 1'b0;
            sgn1  <= 1'b0;
            tag1  <= '0;
            res1  <= '0;
            cmp1  <= '0;
            exp1  <= '0;
            xsig1 <= '0;
            ysig1 <= '0;
        end else if (advance) begin
            v1    <= in_valid;
            spec1 <= c1_spec;
            inv1  <= c1_inv;
            sub1  <= xw[W-1] != yw[W-1];
            sgn1  <= xw[W-1];
            tag1  <= in_tag;
            res1  <= c1_res;
            cmp1  <= c1_cmp;
            exp1  <= xw[W-2 -: EXP_W];
            xsig1 <= xsig;
            ysig1 <= yal;
        end
    end

    logic [SW:0] c2_sum;
    assign c2_sum = sub1 ? {1'b0, xsig1} - {1'b0, ysig1} : {1'b0, xsig1} + {1'b0, ysig1};

    logic             v2, spec2, inv2, sgn2;
    logic [TAG_W-1:0] tag2;
    logic [W-1:0]     res2;
    logic [1:0]       cmp2;
    logic [EXP_W-1:0] exp2;
    logic [SW:0]      sum2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            spec2 <= 1'b0;
            inv2  <= 1'b0;
            sgn2  <= 1'b0;
            tag2  <= '0;
            res2  <= '0;
            cmp2  <= '0;
            exp2  <= '0;
            sum2  <= '0;
        end else if (advance) begin
            v2    <= v1;
            spec2 <= spec1;
            inv2  <= inv1;
            sgn2  <= sgn1;
            tag2  <= tag1;
            res2  <= res1;
            cmp2  <= cmp1;
            exp2  <= exp1;
            sum2  <= c2_sum;
        end
    end

    function automatic logic [LW-1:0] lzc(input logic [SW-1:0] v);
        lzc = LW'(SW);
        for (int i = 0; i < SW; i++)
            if (v[i]) lzc = LW'(SW - 1 - i);
    endfunction

    logic            carry, rup, inx, uf, ovf;
    logic [LW-1:0]   nlz;
    logic [SW-1:0]   mn;
    logic [EW-1:0]   en, er;
    logic [RW-1:0]   mr;
    logic [MAN_W-1:0] fm;
    logic [W-1:0]    c3_res;
    logic [2:0]      c3_flags;

    always_comb begin
        carry    = sum2[SW];
        nlz      = lzc(sum2[SW-1:0]);
        mn       = carry ? {sum2[SW:2], sum2[1] | sum2[0]} : sum2[SW-1:0] << nlz;
        en       = carry ? {2'b00, exp2} + EW'(1) : {2'b00, exp2} - EW'(nlz);
        // mn[2:0] are guard, round, sticky; mn[3] is the result lsb
        rup      = mn[2] && (mn[1] || mn[0] || mn[3]);
        inx      = |mn[2:0];
        mr       = {1'b0, mn[SW-1:3]} + RW'(rup);
        er       = en + EW'(mr[RW-1]);
        fm       = mr[RW-1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
        uf       = en[EW-1] || en == '0;
        ovf      = !uf && er >= {2'b00, EMAX};
        c3_res   = spec2 ? res2 :
                   sum2 == '0 ? '0 :
                   uf ? {sgn2, {(W-1){1'b0}}} :
                   ovf ? {sgn2, EMAX, {MAN_W{1'b0}}} :
                   {sgn2, er[EXP_W-1:0], fm};
        c3_flags = spec2 ? {inv2, 2'b00} :
                   sum2 == '0 ? 3'b000 :
                   uf ? 3'b001 :
                   ovf ? 3'b011 : {2'b00, inx};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            compare   <= '0;
            flags     <= '0;
            out_tag   <= '0;
        end else if (advance) begin
            out_valid <= v2;
            result    <= c3_res;
            compare   <= cmp2;
            flags     <= c3_flags;
            out_tag   <= tag2;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed checks of the pipelined FP add/sub unit in
// single and half precision, including stalls and mid-stream reset.
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, op, out_valid, out_ready;
    logic [31:0] a_i, b_i, result;
    logic [4:0]  tag_i, out_tag;
    logic [1:0]  compare;
    logic [2:0]  flags;

    logic        hin_valid, hin_ready, hop, hout_valid, hout_ready;
    logic [15:0] ha, hb, hresult;
    logic [4:0]  htag, hout_tag;
    logic [1:0]  hcompare;
    logic [2:0]  hflags;

    int total = 0;
    int bad = 0;

    fp_addsub_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a_i), .b(b_i), .in_tag(tag_i), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .compare(compare), .flags(flags), .out_tag(out_tag)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(5)) dut_h (
        .clk(clk), .rst_n(rst_n), .in_valid(hin_valid), .in_ready(hin_ready), .op(hop),
        .a(ha), .b(hb), .in_tag(htag), .out_valid(hout_valid), .out_ready(hout_ready),
        .result(hresult), .compare(hcompare), .flags(hflags), .out_tag(hout_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [31:0] ia, ib, input logic iop, input logic [4:0] itag,
                         output logic [31:0] r, output logic [1:0] c, output logic [2:0] f,
                         output logic [4:0] t, output int lat);
        a_i = ia; b_i = ib; op = iop; tag_i = itag; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        r = result; c = compare; f = flags; t = out_tag;
        @(negedge clk);
    endtask

    task automatic issue_h(input logic [15:0] ia, ib, input logic [4:0] itag,
                           output logic [15:0] r, output logic [1:0] c, output logic [2:0] f,
                           output logic [4:0] t, output int lat);
        ha = ia; hb = ib; hop = 1'b0; htag = itag; hin_valid = 1'b1; hout_ready = 1'b1;
        @(posedge clk);
        #1 hin_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!hout_valid && lat < 20);
        r = hresult; c = hcompare; f = hflags; t = hout_tag;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({out_valid, result, compare, flags, out_tag} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b r=%h c=%0d f=%b t=%0d want all zero",
                     out_valid, result, compare, flags, out_tag);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || hin_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got %b/%b want 1/1", in_ready, hin_ready);
        end
    endtask

    task automatic test_arith();
        logic [31:0] va [0:16], vb [0:16], vr [0:16];
        logic        vo [0:16];
        logic [1:0]  vc [0:16];
        logic [2:0]  vf [0:16];
        logic [31:0] r;
        logic [1:0]  c;
        logic [2:0]  f;
        logic [4:0]  t;
        int          lat;
        va = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h3F800000, 32'h3F800001,
               32'h3F800000, 32'h7F7FFFFF, 32'h7F800000, 32'h7F800001, 32'h3F800000,
               32'hC0000000, 32'h3F800000, 32'h00000000, 32'h7F800000, 32'hFF800000,
               32'h3F800000, 32'h80000000};
        vb = '{32'h40000000, 32'h3F800000, 32'h80000000, 32'h33800000, 32'h33800000,
               32'h00800000, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000, 32'h3F400000,
               32'hBF800000, 32'hC0000000, 32'h40000000, 32'h3F800000, 32'h7F800000,
               32'h00000001, 32'h00000000};
        vo = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vr = '{32'h40400000, 32'h00000000, 32'h80000000, 32'h3F800000, 32'h3F800002,
               32'h3F800000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h3E800000,
               32'hC0400000, 32'hBF800000, 32'hC0000000, 32'h7F800000, 32'hFF800000,
               32'h3F800000, 32'h00000000};
        vc = '{2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd3, 2'd0,
               2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2};
        vf = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b011, 3'b100, 3'b100,
               3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        for (int i = 0; i < 17; i++) begin
            issue(va[i], vb[i], vo[i], 5'(i + 1), r, c, f, t, lat);
            total++;
            if (lat !== 3) begin
                bad++;
                $display("FAIL arith[%0d] latency got %0d want 3", i, lat);
            end
            total++;
            if (r !== vr[i]) begin
                bad++;
                $display("FAIL arith[%0d] result got %h want %h", i, r, vr[i]);
            end
            total++;
            if (c !== vc[i]) begin
                bad++;
                $display("FAIL arith[%0d] compare got %0d want %0d", i, c, vc[i]);
            end
            total++;
            if (f !== vf[i]) begin
                bad++;
                $display("FAIL arith[%0d] flags got %b want %b", i, f, vf[i]);
            end
            total++;
            if (t !== 5'(i + 1)) begin
                bad++;
                $display("FAIL arith[%0d] tag got %0d want %0d", i, t, i + 1);
            end
        end
    endtask

    task automatic test_half();
        logic [15:0] r;
        logic [1:0]  c;
        logic [2:0]  f;
        logic [4:0]  t;
        int          lat;
        issue_h(16'h3C00, 16'h4000, 5'd21, r, c, f, t, lat);
        total++;
        if (r !== 16'h4200 || c !== 2'd1 || f !== 3'b000 || t !== 5'd21 || lat !== 3) begin
            bad++;
            $display("FAIL half_add got r=%h c=%0d f=%b t=%0d lat=%0d want 4200 1 000 21 3",
                     r, c, f, t, lat);
        end
        issue_h(16'h7BFF, 16'h7BFF, 5'd22, r, c, f, t, lat);
        total++;
        if (r !== 16'h7C00 || c !== 2'd2 || f !== 3'b011 || t !== 5'd22 || lat !== 3) begin
            bad++;
            $display("FAIL half_ovf got r=%h c=%0d f=%b t=%0d lat=%0d want 7c00 2 011 22 3",
                     r, c, f, t, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ba [0:5], bb [0:5], br [0:5];
        logic        bo [0:5];
        logic [31:0] hold_r;
        logic [4:0]  hold_t;
        logic [2:0]  hold_f;
        logic [1:0]  hold_c;
        logic        do_in, moved, dup;
        int          sent, got;
        ba = '{32'h3F800000, 32'h3F800000, 32'h3F800001, 32'h3F800000, 32'hC0000000, 32'h3F800000};
        bb = '{32'h40000000, 32'h3F800000, 32'h33800000, 32'h3F400000, 32'hBF800000, 32'hC0000000};
        bo = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        br = '{32'h40400000, 32'h00000000, 32'h3F800002, 32'h3E800000, 32'hC0400000, 32'hBF800000};
        sent = 0;
        got = 0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            a_i = ba[sent]; b_i = bb[sent]; op = bo[sent]; tag_i = 5'(10 + sent);
            in_valid = 1'b1;
            #1;
            if (!in_ready) break;
            @(posedge clk);
            sent++;
            @(negedge clk);
        end
        total++;
        if (sent !== 3 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_fill accepted %0d in_ready=%b want 3 and 0", sent, in_ready);
        end
        total++;
        if (out_valid !== 1'b1 || out_tag !== 5'd10) begin
            bad++;
            $display("FAIL b2b_head got v=%b tag=%0d want 1 and 10", out_valid, out_tag);
        end
        hold_r = result; hold_t = out_tag; hold_f = flags; hold_c = compare;
        moved = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            if (result !== hold_r || out_tag !== hold_t || flags !== hold_f ||
                compare !== hold_c || out_valid !== 1'b1 || in_ready !== 1'b0) moved = 1'b1;
        end
        total++;
        if (moved !== 1'b0) begin
            bad++;
            $display("FAIL b2b_stall outputs changed while stalled got r=%h t=%0d want r=%h t=%0d",
                     result, out_tag, hold_r, hold_t);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 30 && got < 6; k++) begin
            in_valid = sent < 6;
            if (sent < 6) begin
                a_i = ba[sent]; b_i = bb[sent]; op = bo[sent]; tag_i = 5'(10 + sent);
            end
            #1;
            do_in = in_valid && in_ready;
            if (out_valid) begin
                total++;
                if (result !== br[got] || out_tag !== 5'(10 + got)) begin
                    bad++;
                    $display("FAIL b2b_out[%0d] got r=%h t=%0d want r=%h t=%0d",
                             got, result, out_tag, br[got], 10 + got);
                end
                got++;
            end
            @(posedge clk);
            if (do_in) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++;
        if (got !== 6 || sent !== 6) begin
            bad++;
            $display("FAIL b2b_count got out=%0d in=%0d want 6 and 6", got, sent);
        end
        dup = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (out_valid !== 1'b0) dup = 1'b1;
            @(negedge clk);
        end
        total++;
        if (dup !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain extra result seen tag=%0d want none", out_tag);
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] r;
        logic [1:0]  c;
        logic [2:0]  f;
        logic [4:0]  t;
        int          lat;
        logic        stale;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_i = 32'h3F800000; b_i = 32'h40000000; op = 1'b0; tag_i = 5'(k + 1);
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_full got v=%b in_ready=%b want 1 and 0", out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, result, compare, flags, out_tag} !== '0) begin
            bad++;
            $display("FAIL mid_async_clear got v=%b r=%h t=%0d want all zero",
                     out_valid, result, out_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (out_valid !== 1'b0) stale = 1'b1;
            @(negedge clk);
        end
        total++;
        if (stale !== 1'b0) begin
            bad++;
            $display("FAIL mid_stale result after reset tag=%0d want none", out_tag);
        end
        issue(32'h3F800001, 32'h33800000, 1'b0, 5'd30, r, c, f, t, lat);
        total++;
        if (r !== 32'h3F800002 || t !== 5'd30 || f !== 3'b001 || lat !== 3) begin
            bad++;
            $display("FAIL mid_next got r=%h t=%0d f=%b lat=%0d want 3f800002 30 001 3",
                     r, t, f, lat);
        end
    endtask

    initial begin
        in_valid = 1'b0; op = 1'b0; out_ready = 1'b1; a_i = '0; b_i = '0; tag_i = '0;
        hin_valid = 1'b0; hop = 1'b0; hout_ready = 1'b1; ha = '0; hb = '0; htag = '0;
        test_reset();
        test_arith();
        test_half();
        test_back_to_back();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_addsub_pipe.md
# fp_addsub_pipe

Parametrised, pipelined IEEE-754-style floating-point add/subtract unit with compare. It supersedes the combinational FP adder in the FPU path of the rv-pipeline datapath, adding:

- configurable exponent and mantissa widths;
- a 3-stage pipeline with valid/ready handshaking;
- round-to-nearest-even, special-value handling and exception flags;
- a tag that carries destination metadata through the pipeline.

It sits between the execute-stage FPU issue logic and the FP writeback arbiter.

## Interface
Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored mantissa width (hidden bit excluded); W = 1+EXP_W+MAN_W.
- TAG_W, 5, width of opaque tag carried with each operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit accepts the operation this cycle.
- op  in  1  0 = a+b, 1 = a−b.
- a, b  in  W  operands {sign, exponent, mantissa}.
- in_tag  in  TAG_W  metadata returned with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  W  rounded sum/difference.
- compare  out  2  0: a>b, 1: a<b, 2: a==b, 3: unordered (NaN operand).
- flags  out  3  {invalid, overflow, inexact}.
- out_tag  out  TAG_W  in_tag of this result.

## Operation
- Transfer on in_valid&&in_ready; result leaves on out_valid&&out_ready.
- Subtraction is implemented as addition with b's sign inverted (b' sign = b[W-1]^op).
- Input classification:
  - exp==0: zero, flush-to-zero (subnormals treated as ±0).
  - exp all-ones, mantissa==0: ±inf.
  - exp all-ones, mantissa!=0: NaN.
- Stage 1 (align):
  - Classify; compute compare; swap so the larger-magnitude operand is X.
  - Shift Y's significand right by the exponent difference into MAN_W+4 bits: hidden, mantissa, guard, round, sticky.
  - Shifts ≥ MAN_W+3 collapse Y to sticky only (sticky = 1 if Y nonzero).
- Stage 2 (add):
  - Same effective sign: add significands, carry-out possible.
  - Different effective sign: X−Y, result ≥ 0 by construction.
  - Result sign is X's effective sign.
- Stage 3 (normalize/round):
  - Carry-out: shift right 1 (OR shifted-out bit into sticky), exponent+1.
  - Otherwise: leading-zero count, shift left, exponent−lzc.
  - Round-to-nearest-even on guard/round/sticky; a rounding carry renormalises.
- Exact-zero sum: +0 (x+(−x)=+0). (−0)+(−0) gives −0.
- Exponent ≤ 0 after normalization: result ±0, inexact=1.
- Exponent ≥ all-ones after rounding: ±inf, overflow=1, inexact=1.
- Special values:
  - Any NaN input: canonical qNaN (sign 0, exp all-ones, mantissa MSB 1, rest 0), compare=3.
  - Signalling NaN input (mantissa MSB 0): invalid=1.
  - inf−inf (effective): qNaN, invalid=1.
  - inf±finite: that inf, no flags.
  - Zero operand: other operand passes through exactly (with op sign applied to b).
- compare is sign-aware and ignores op; +0 and −0 compare equal; compare is computed on the original b.
- inexact is set whenever any of guard/round/sticky is nonzero at rounding.

## Timing
- Latency: exactly 3 cycles from accept to out_valid when not stalled.
- Throughput: 1 op/cycle.
- Global-stall pipeline: advance = !out_valid || out_ready; in_ready = advance.
- Combinational paths: out_ready→in_ready only; no other input→output paths.
- While out_valid=1 && out_ready=0, result/compare/flags/out_tag hold stable and no stage moves.
- Bubbles propagate as valid=0; a full pipeline with out_ready=0 holds 3 ops.
- Simultaneous accept and output in the same cycle are allowed; occupancy is unchanged.
- Reset (async, any time, including mid-stream):
  - All stage valids clear immediately; out_valid=0, result=0, compare=0, flags=0, out_tag=0.
  - In-flight ops are discarded.
  - in_ready=1 from the first cycle after reset release.

## Test plan
- Basic add, single precision: a=0x3F800000, b=0x40000000, op=0 → result 0x40400000 three cycles later, compare=1, flags=000, tag returned unchanged.
- Cancellation: a=b=0x3F800000, op=1 → 0x00000000, compare=2. Signed zero: a=0x80000000, b=0x80000000, op=0 → 0x80000000.
- RNE ties:
  - 0x3F800000+0x33800000 → 0x3F800000, inexact=1.
  - 0x3F800001+0x33800000 → 0x3F800002, inexact=1.
  - Large alignment: 0x3F800000+0x00800000 → 0x3F800000, inexact=1.
- Overflow/specials:
  - 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000, flags=011.
  - 0x7F800000−0x7F800000 → 0x7FC00000, invalid=1, compare=2.
  - 0x7F800001+0x3F800000 → 0x7FC00000, invalid=1, compare=3.
- Backpressure: 6 back-to-back ops with out_ready=0 for cycles 2–7 → in_ready falls once 3 are held; all 6 results emerge in order, no loss or duplication; outputs stable while stalled.
- Reset mid-stream: assert rst_n=0 with 3 ops in flight → out_valid drops asynchronously; after release no stale result appears; the next op completes with 3-cycle latency.
- Parameter sweep: EXP_W=5, MAN_W=10 (half precision): 0x3C00+0x4000 → 0x4200; 0x7BFF+0x7BFF → 0x7C00 with overflow=1.
